// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: buffers sprite-update requests and serializes them into
// 32-bit writedata command words; issues the buffer-flush word at vblank start.
// Optional build macro SPRITE_CMD_GAP_EN inserts one idle word between the
// command words of an entry.
module sprite_cmd_encoder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [5:0]  upd_sub_comp,
  input  logic [4:0]  upd_child,
  input  logic [3:0]  upd_mask,
  input  logic        upd_visible,
  input  logic        upd_flip,
  input  logic [4:0]  upd_pattern,
  input  logic [9:0]  upd_x,
  input  logic [9:0]  upd_y,
  input  logic [9:0]  upd_shift,
  input  logic [9:0]  vcount,
  output logic [31:0] writedata,
  output logic        front_buf,
  output logic        frame_done,
  output logic        flush_overrun
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [5:0] sub_comp;
    logic [4:0] child;
    logic [3:0] mask;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } upd_t;

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  upd_t            mem_q [FIFO_DEPTH];
  upd_t            upd_in;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;

  state_t          state_q, state_d;
  upd_t            work_q, work_d;
  logic            gap_q, gap_d;
  logic [31:0]     writedata_q, writedata_d;
  logic            front_buf_q, front_buf_d;
  logic            frame_done_q, frame_done_d;
  logic            flush_pending_q, flush_pending_d;
  logic            overrun_q, overrun_d;
  logic            flush_clr;
  logic [9:0]      vcount_q;
  logic            vblank_edge;
  logic [3:0]      sel;

  assign upd_in = '{sub_comp: upd_sub_comp, child: upd_child, mask: upd_mask,
                    visible: upd_visible, flip: upd_flip, pattern: upd_pattern,
                    x: upd_x, y: upd_y, shift: upd_shift};

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign push        = upd_valid && !full;
  assign upd_ready   = !full;
  assign vblank_edge = (vcount_q != 10'(VBLANK_LINE)) && (vcount == 10'(VBLANK_LINE));

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= upd_in;
  end

  // Flush request tracking; edges arriving while one is pending coalesce
  always_comb begin
    flush_pending_d = (flush_pending_q && !flush_clr) || vblank_edge;
    overrun_d       = overrun_q || (vblank_edge && flush_pending_q && !flush_clr);
  end

  // Lowest set mask bit selects the next word (attr, x, y, shift order)
  assign sel = work_q.mask & 4'(~work_q.mask + 4'd1);

  // Sequencer next-state and word generation
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    gap_d        = 1'b0;
    writedata_d  = 32'h0;
    front_buf_d  = front_buf_q;
    frame_done_d = 1'b0;
    flush_clr    = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_pending_q) begin
          state_d = FLUSH;
        end else if (!empty) begin
          pop     = 1'b1;
          work_d  = mem_q[rd_ptr_q];
          state_d = SEND;
        end
      end
      SEND: begin
        if (gap_q) begin
          state_d = SEND;
        end else if (work_q.mask == 4'b0000) begin
          state_d = IDLE;
        end else begin
          if (sel[0]) begin
            writedata_d = {work_q.sub_comp, work_q.child, 4'b0001, 3'b001, ~front_buf_q,
                           work_q.visible, work_q.flip, 6'b0, work_q.pattern};
          end else if (sel[1]) begin
            writedata_d = {work_q.sub_comp, work_q.child, 4'b0001, 3'b010, ~front_buf_q,
                           3'b0, work_q.x};
          end else if (sel[2]) begin
            writedata_d = {work_q.sub_comp, work_q.child, 4'b0001, 3'b011, ~front_buf_q,
                           3'b0, work_q.y};
          end else begin
            writedata_d = {work_q.sub_comp, work_q.child, 4'b0001, 3'b100, ~front_buf_q,
                           3'b0, work_q.shift};
          end
          work_d.mask = work_q.mask & ~sel;
          if (work_d.mask == 4'b0000) state_d = IDLE;
`ifdef SPRITE_CMD_GAP_EN
          gap_d = (work_d.mask != 4'b0000);
`else
          gap_d = 1'b0;
`endif
        end
      end
      FLUSH: begin
        writedata_d  = {6'b0, 5'b0, 4'b1111, 3'b000, ~front_buf_q, 13'b0};
        front_buf_d  = ~front_buf_q;
        frame_done_d = 1'b1;
        flush_clr    = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      state_q         <= IDLE;
      work_q          <= '0;
      gap_q           <= 1'b0;
      writedata_q     <= 32'h0;
      front_buf_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      flush_pending_q <= 1'b0;
      overrun_q       <= 1'b0;
      vcount_q        <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      state_q         <= state_d;
      work_q          <= work_d;
      gap_q           <= gap_d;
      writedata_q     <= writedata_d;
      front_buf_q     <= front_buf_d;
      frame_done_q    <= frame_done_d;
      flush_pending_q <= flush_pending_d;
      overrun_q       <= overrun_d;
      vcount_q        <= vcount;
    end
  end

  assign writedata     = writedata_q;
  assign front_buf     = front_buf_q;
  assign frame_done    = frame_done_q;
  assign flush_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Scoreboard bench for sprite_cmd_encoder: stimulus queues expected words,
// a negedge monitor pops and compares every word the DUT presents.
module tb_sprite_cmd_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_sub_comp;
  logic [4:0]  upd_child;
  logic [3:0]  upd_mask;
  logic        upd_visible;
  logic        upd_flip;
  logic [4:0]  upd_pattern;
  logic [9:0]  upd_x, upd_y, upd_shift;
  logic [9:0]  vcount;
  logic [31:0] writedata;
  logic        front_buf;
  logic        frame_done;
  logic        flush_overrun;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic        saw_full;

  always #5 clk = ~clk;

  sprite_cmd_encoder #(.FIFO_DEPTH(8), .VBLANK_LINE(480)) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_sub_comp(upd_sub_comp), .upd_child(upd_child), .upd_mask(upd_mask),
    .upd_visible(upd_visible), .upd_flip(upd_flip), .upd_pattern(upd_pattern),
    .upd_x(upd_x), .upd_y(upd_y), .upd_shift(upd_shift),
    .vcount(vcount), .writedata(writedata), .front_buf(front_buf),
    .frame_done(frame_done), .flush_overrun(flush_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] cmd(input logic [5:0] s, input logic [4:0] c,
                                      input logic [2:0] t, input logic pp, input logic [12:0] m);
    return {s, c, 4'b0001, t, pp, m};
  endfunction

  function automatic logic [31:0] flush_word(input logic pp);
    return {15'h0, 4'b1111, 3'b000, pp, 13'h0};
  endfunction

  // Queue the expected words of one entry in attr, x, y, shift order
  task automatic exp_entry(input logic [5:0] s, input logic [4:0] c, input logic [3:0] m,
                           input logic v, input logic f, input logic [4:0] p,
                           input logic [9:0] x, input logic [9:0] y, input logic [9:0] sh,
                           input logic pp);
    if (m[0]) exp_q.push_back(cmd(s, c, 3'b001, pp, {v, f, 6'b0, p}));
    if (m[1]) exp_q.push_back(cmd(s, c, 3'b010, pp, {3'b0, x}));
    if (m[2]) exp_q.push_back(cmd(s, c, 3'b011, pp, {3'b0, y}));
    if (m[3]) exp_q.push_back(cmd(s, c, 3'b100, pp, {3'b0, sh}));
  endtask

  // Present one update and hold it until accepted (bounded)
  task automatic push(input logic [5:0] s, input logic [4:0] c, input logic [3:0] m,
                      input logic v, input logic f, input logic [4:0] p,
                      input logic [9:0] x, input logic [9:0] y, input logic [9:0] sh);
    int k;
    @(negedge clk);
    upd_valid = 1'b1; upd_sub_comp = s; upd_child = c; upd_mask = m;
    upd_visible = v; upd_flip = f; upd_pattern = p; upd_x = x; upd_y = y; upd_shift = sh;
    k = 0;
    while (!upd_ready && k < 40) begin
      saw_full = 1'b1;
      @(negedge clk);
      k++;
    end
    if (!upd_ready) begin
      chk("push_timeout", 32'(upd_ready), 32'd1);
      upd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 upd_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for the scoreboard to empty
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every presented word must match the scoreboard head
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (writedata != 32'h0 || frame_done)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", writedata, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("word", writedata, e);
          chk("frame_done", 32'(frame_done), 32'(e[20:17] == 4'b1111));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nz;
    reset = 1'b0; upd_valid = 1'b0; upd_sub_comp = '0; upd_child = '0; upd_mask = '0;
    upd_visible = 1'b0; upd_flip = 1'b0; upd_pattern = '0; upd_x = '0; upd_y = '0;
    upd_shift = '0; vcount = '0; saw_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_front_buf", 32'(front_buf), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overrun", 32'(flush_overrun), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Basic two-word entry with exact latency
    exp_q.push_back(32'h3C02_7000);
    exp_q.push_back(32'h3C02_A064);
    push(6'd15, 5'd0, 4'b0011, 1'b1, 1'b0, 5'd0, 10'd100, 10'd0, 10'd0);
    @(negedge clk); chk("s1_lat0", writedata, 32'h0);
    @(negedge clk); chk("s1_lat1", writedata, 32'h0);
    @(negedge clk); chk("s1_attr", writedata, 32'h3C02_7000);
`ifdef SPRITE_CMD_GAP_EN
    @(negedge clk); chk("s1_gap", writedata, 32'h0);
`endif
    @(negedge clk); chk("s1_x", writedata, 32'h3C02_A064);
    @(negedge clk); chk("s1_idle", writedata, 32'h0);
    drain();

    // Vblank edge while idle
    vcount = 10'd479;
    @(negedge clk); vcount = 10'd480;
    exp_q.push_back(32'h001E_2000);
    @(posedge clk);
    @(negedge clk); chk("s2_lat0", writedata, 32'h0); chk("s2_fb_before", 32'(front_buf), 32'd0);
    @(negedge clk); chk("s2_lat1", writedata, 32'h0);
    @(negedge clk); chk("s2_flush", writedata, 32'h001E_2000);
    chk("s2_fb_after", 32'(front_buf), 32'd1);
    chk("s2_frame_done", 32'(frame_done), 32'd1);
    @(negedge clk); chk("s2_frame_done_pulse", 32'(frame_done), 32'd0);
    vcount = 10'd0;
    exp_q.push_back(32'h0442_C155);
    push(6'd1, 5'd2, 4'b0100, 1'b0, 1'b0, 5'd0, 10'd0, 10'h155, 10'd0);
    drain();

    // Back-to-back pushes until the FIFO fills
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_entry(6'(i + 1), 5'(i), 4'b1111, i[0], i[1], 5'(i), 10'(10 * i), 10'(i + 200),
                10'(i + 500), 1'b0);
      push(6'(i + 1), 5'(i), 4'b1111, i[0], i[1], 5'(i), 10'(10 * i), 10'(i + 200),
           10'(i + 500));
    end
    chk("s3_saw_full", 32'(saw_full), 32'd1);
    drain();

    // Two vblank edges during a 4-word entry
    exp_entry(6'd2, 5'd3, 4'b1111, 1'b0, 1'b0, 5'd7, 10'd1, 10'd2, 10'd3, 1'b0);
    exp_q.push_back(32'h001E_0000);
    @(negedge clk); vcount = 10'd479;
    push(6'd2, 5'd3, 4'b1111, 1'b0, 1'b0, 5'd7, 10'd1, 10'd2, 10'd3);
    @(negedge clk);
    @(negedge clk); vcount = 10'd480;
    @(negedge clk); vcount = 10'd479;
    @(negedge clk); vcount = 10'd480;
    @(negedge clk); vcount = 10'd0;
    drain();
    chk("s4_overrun", 32'(flush_overrun), 32'd1);
    chk("s4_front_buf", 32'(front_buf), 32'd0);

    // Mask-0 entry followed immediately by a one-word entry
    exp_q.push_back(32'hFFE2_681F);
    push(6'd7, 5'd1, 4'b0000, 1'b1, 1'b1, 5'd3, 10'd9, 10'd9, 10'd9);
    push(6'd63, 5'd31, 4'b0001, 1'b0, 1'b1, 5'd31, 10'd0, 10'd0, 10'd0);
    @(negedge clk); chk("s5_idle0", writedata, 32'h0);
    @(negedge clk); chk("s5_idle1", writedata, 32'h0);
    @(negedge clk); chk("s5_idle2", writedata, 32'h0);
    @(negedge clk); chk("s5_word", writedata, 32'hFFE2_681F);
    drain();

    // Reset on the third word of an entry with another entry queued
    exp_entry(6'd5, 5'd9, 4'b1111, 1'b1, 1'b1, 5'd5, 10'h3FF, 10'h200, 10'h001, 1'b1);
    exp_entry(6'd6, 5'd4, 4'b0011, 1'b0, 1'b0, 5'd1, 10'd7, 10'd0, 10'd0, 1'b1);
    push(6'd5, 5'd9, 4'b1111, 1'b1, 1'b1, 5'd5, 10'h3FF, 10'h200, 10'h001);
    push(6'd6, 5'd4, 4'b0011, 1'b0, 1'b0, 5'd1, 10'd7, 10'd0, 10'd0);
    @(negedge clk); chk("s6_lat", writedata, 32'h0);
    @(negedge clk); chk("s6_w0", writedata, 32'h1522_7805);
`ifdef SPRITE_CMD_GAP_EN
    @(negedge clk); chk("s6_gap", writedata, 32'h0);
    repeat (3) @(posedge clk);
`else
    @(negedge clk); chk("s6_w1", writedata, 32'h1522_A3FF);
    @(posedge clk);
`endif
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("s6_rst_writedata", writedata, 32'h0);
    chk("s6_rst_overrun", 32'(flush_overrun), 32'd0);
    chk("s6_rst_frame_done", 32'(frame_done), 32'd0);
    chk("s6_rst_front_buf", 32'(front_buf), 32'd0);
    chk("s6_rst_ready", 32'(upd_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nz = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (writedata != 32'h0) nz++;
    end
    chk("s6_fifo_empty", 32'(nz), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
